// File: rtl/booth_div_nbit_seq.sv
// Sequential N-bit restoring divider: one quotient bit per RUN cycle.
// Define DIV_ZERO_DETECT_EN to short-cut zero divisors and raise div_by_zero.
module booth_div_nbit_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quot,
  output logic [N-1:0] Rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [2*N:0]  sh;
  logic [N:0]    diff;
  logic [N:0]    a_nx;
  logic [N-1:0]  q_nx;
  logic          last;
  logic          dz;

  // shift {A,Q}, trial-subtract D, restore on a negative result
  always_comb begin
    sh   = {a, q} << 1;
    diff = sh[2*N:N] - {1'b0, d};
    if (!diff[N]) begin
      a_nx = diff;
      q_nx = {sh[N-1:1], 1'b1};
    end else begin
      a_nx = sh[2*N:N];
      q_nx = sh[N-1:0];
    end
  end

  assign last = (cnt == CW'(N - 1));

`ifdef DIV_ZERO_DETECT_EN
  assign dz = (d == '0);
`else
  assign dz = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (dz || last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      Quot  <= '0;
      Rem   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            a   <= '0;
            q   <= Dividend;
            d   <= Divisor;
            cnt <= '0;
          end
        end
        RUN: begin
          if (dz) begin
            Quot <= '1;
            Rem  <= q;
          end else begin
            a   <= a_nx;
            q   <= q_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
              Quot <= q_nx;
              Rem  <= a_nx[N-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      div_by_zero <= 1'b0;
    else if (state == IDLE && start)
      div_by_zero <= 1'b0;
    else if (state == RUN && dz)
      div_by_zero <= 1'b1;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_booth_div_nbit_seq.sv
// Bench for booth_div_nbit_seq (N=4): arithmetic model plus directed
// and random divisions, checked by a per-cycle compare process.
module tb_booth_div_nbit_seq;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] Dividend;
  logic [3:0] Divisor;
  logic [3:0] Quot;
  logic [3:0] Rem;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  int  ea, eb, eq, er;
  bit  edz;
  bit  pending = 1'b0;

  booth_div_nbit_seq #(.N(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Quot(Quot),
    .Rem(Rem),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int mq(input int x, input int y);
    return (y == 0) ? 15 : x / y;
  endfunction

  function automatic int mr(input int x, input int y);
    return (y == 0) ? x : x % y;
  endfunction

  // compare process: every done cycle must match the model
  initial forever begin
    @(negedge clk);
    if (done) begin
      chk("done_expected", int'(pending), 1);
      chk("quot", int'(Quot), eq);
      chk("rem", int'(Rem), er);
      chk("div_by_zero", int'(div_by_zero), int'(edz));
      if (eb != 0) begin
        chk("identity", int'(Quot) * eb + int'(Rem), ea);
        chk("rem_lt_div", int'(int'(Rem) < eb), 1);
      end
      pending = 1'b0;
    end
  end

  task automatic do_div(input logic [3:0] x, input logic [3:0] y,
                        input bit inj);
    int lat;
    int bcnt;
    int explat;
    @(negedge clk);
    Dividend = x;
    Divisor  = y;
    start    = 1'b1;
    ea  = int'(x);
    eb  = int'(y);
    eq  = mq(ea, eb);
    er  = mr(ea, eb);
    edz = DZ && (y == 4'd0);
    pending = 1'b1;
    explat = (DZ && y == 4'd0) ? 2 : 5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    Dividend = ~x;
    Divisor  = y ^ 4'h5;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (inj && lat == 2) begin
        start    = 1'b1;
        Dividend = 4'd2;
        Divisor  = 4'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk("latency", done ? lat : -1, explat);
    chk("busy_cycles", bcnt, explat - 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    #1;
    chk("rst_quot", int'(Quot), 0);
    chk("rst_rem", int'(Rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    chk("pin_13_3_q", mq(13, 3), 4);
    chk("pin_13_3_r", mr(13, 3), 1);
    chk("pin_15_1_q", mq(15, 1), 15);
    chk("pin_7_9_r", mr(7, 9), 7);
    chk("pin_9_0_q", mq(9, 0), 15);
    chk("pin_9_0_r", mr(9, 0), 9);
    chk("pin_10_4_q", mq(10, 4), 2);
    chk("pin_10_4_r", mr(10, 4), 2);

    do_div(4'd13, 4'd3, 1'b0);
    do_div(4'd15, 4'd1, 1'b0);
    do_div(4'd7, 4'd9, 1'b0);
    do_div(4'd9, 4'd0, 1'b0);
    do_div(4'd13, 4'd3, 1'b1);

    // abort mid-run: outputs clear at once and no done follows
    @(negedge clk);
    Dividend = 4'd13;
    Divisor  = 4'd3;
    start    = 1'b1;
    pending  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_quot", int'(Quot), 0);
    chk("abort_rem", int'(Rem), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", int'(done), 0);
    end
    do_div(4'd10, 4'd4, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] rx;
      logic [3:0] ry;
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      do_div(rx, ry, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
